// File: rtl/alu_addsub_arbiter.sv
// Two-port round-robin arbiter in front of one shared add/subtract datapath.
// Capture/negate cycle (IDLE) followed by add/result cycle (EXEC).
module alu_addsub_arbiter #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              op0,
  input  logic [DWIDTH-1:0] a0,
  input  logic [DWIDTH-1:0] b0,
  input  logic              req1,
  input  logic              op1,
  input  logic [DWIDTH-1:0] a1,
  input  logic [DWIDTH-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic [DWIDTH-1:0] dout,
  output logic              cout,
  output logic              valid,
  output logic              valid_id
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state, state_nx;
  logic [DWIDTH-1:0] a_r, b_r;
  logic              cin_r, id_r, last_served;

  logic              take, win, op_w;
  logic [DWIDTH-1:0] a_w, b_w;
  logic [DWIDTH:0]   sum;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          // On a tie the port that was not served last wins.
          win      = (req0 && req1) ? ~last_served : req1;
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    op_w = win ? op1 : op0;
    a_w  = win ? a1  : a0;
    b_w  = win ? b1  : b0;
    sum  = {1'b0, a_r} + {1'b0, b_r} + {{DWIDTH{1'b0}}, cin_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      cin_r       <= 1'b0;
      id_r        <= 1'b0;
      last_served <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      dout        <= '0;
      cout        <= 1'b0;
      valid       <= 1'b0;
      valid_id    <= 1'b0;
    end else begin
      state <= state_nx;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      valid <= 1'b0;
      if (take) begin
        // Subtract is folded into the operand: b inverted here, +1 via carry-in.
        a_r   <= a_w;
        b_r   <= op_w ? ~b_w : b_w;
        cin_r <= op_w;
        id_r  <= win;
        gnt0  <= ~win;
        gnt1  <= win;
        busy  <= 1'b1;
      end
      if (state == EXEC) begin
        {cout, dout} <= sum;
        valid        <= 1'b1;
        valid_id     <= id_r;
        last_served  <= id_r;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Scoreboard bench for alu_addsub_arbiter: driver pushes expected results at
// grant time, a negedge monitor checks arbitration, timing and results.
module tb_alu_addsub_arbiter;

  logic       clk, rst;
  logic       req0, op0, req1, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, cout, valid, valid_id;
  logic [7:0] dout;

  logic       r_req [2];
  logic       r_op  [2];
  logic [7:0] r_a   [2];
  logic [7:0] r_b   [2];

  assign req0 = r_req[0];
  assign op0  = r_op[0];
  assign a0   = r_a[0];
  assign b0   = r_b[0];
  assign req1 = r_req[1];
  assign op1  = r_op[1];
  assign a1   = r_a[1];
  assign b1   = r_b[1];

  alu_addsub_arbiter #(.DWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .dout(dout), .cout(cout), .valid(valid), .valid_id(valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] d;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands the port presented.
  task automatic push_exp(input int p);
    exp_t e;
    int   a, b, s;
    a = int'(r_a[p]);
    b = int'(r_b[p]);
    e.id = (p == 1);
    if (r_op[p]) begin
      s   = a - b;
      e.c = (a >= b);
    end else begin
      s   = a + b;
      e.c = (s > 255);
    end
    e.d = s[7:0];
    exp_q.push_back(e);
  endtask

  // Monitor: models the arbiter at the level of "who asked, who was served last".
  logic       m_last;
  logic       m_gprev;
  logic [1:0] m_rprev;
  logic [1:0] m_eg;
  exp_t       m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_last  = 1'b1;
      m_gprev = 1'b0;
      m_rprev = 2'b00;
    end else begin
      m_eg = 2'b00;
      if (!m_gprev) begin
        case (m_rprev)
          2'b01:   m_eg = 2'b01;
          2'b10:   m_eg = 2'b10;
          2'b11:   m_eg = m_last ? 2'b01 : 2'b10;
          default: m_eg = 2'b00;
        endcase
      end
      check("grant", int'({gnt1, gnt0}), int'(m_eg));
      check("busy", int'(busy), int'(|m_eg));
      check("valid_timing", int'(valid), int'(m_gprev));
      if (valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL result: valid with no expected result at %0t", $time);
        end else begin
          m_e = exp_q.pop_front();
          check("valid_id", int'(valid_id), int'(m_e.id));
          check("dout", int'(dout), int'(m_e.d));
          check("cout", int'(cout), int'(m_e.c));
        end
      end
      if (m_eg != 2'b00) m_last = m_eg[1];
      m_gprev = |m_eg;
      m_rprev = {req1, req0};
    end
  end

  function automatic logic gnt_of(input int p);
    return (p == 1) ? gnt1 : gnt0;
  endfunction

  // One request on port p; operand a is scrambled after grant to prove capture.
  task automatic port_op(input int p, input logic op, input logic [7:0] a, input logic [7:0] b);
    bit done;
    done = 0;
    r_req[p] = 1'b1;
    r_op[p]  = op;
    r_a[p]   = a;
    r_b[p]   = b;
    for (int unsigned i = 0; i < 10 && !done; i++) begin
      @(posedge clk); #1;
      if (gnt_of(p)) begin
        push_exp(p);
        r_req[p] = 1'b0;
        r_a[p]   = ~a;
        r_op[p]  = ~op;
        done     = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL port_op_timeout: port %0d no grant, expected grant within 10 cycles", p);
      r_req[p] = 1'b0;
    end
  endtask

  int wait_cnt [2];
  int got;

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_op[i] = 1'b0; r_a[i] = '0; r_b[i] = '0;
    end
    rst = 1'b1;
    #1;
    check("rst_gnt", int'({gnt1, gnt0}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_valid_id", int'(valid_id), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    port_op(0, 1'b0, 8'h25, 8'h13);
    port_op(1, 1'b1, 8'h05, 8'h07);
    port_op(1, 1'b1, 8'h40, 8'h40);
    port_op(0, 1'b0, 8'hFF, 8'h02);
    port_op(1, 1'b0, 8'h80, 8'h80);
    port_op(0, 1'b1, 8'h00, 8'h01);

    // Reset while the operation is in EXEC: discard it, clear outputs at once.
    r_req[1] = 1'b1; r_op[1] = 1'b0; r_a[1] = 8'h11; r_b[1] = 8'h22;
    got = 0;
    for (int unsigned i = 0; i < 10 && got == 0; i++) begin
      @(posedge clk); #1;
      if (gnt1) got = 1;
    end
    check("midrst_grant_seen", got, 1);
    r_req[1] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_gnt", int'({gnt1, gnt0}), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_cout", int'(cout), 0);
    check("midrst_valid_id", int'(valid_id), 0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b1; r_op[i] = 1'($urandom); r_a[i] = 8'($urandom); r_b[i] = 8'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Both ports requesting continuously: grants must alternate starting at 0.
    for (int unsigned k = 0; k < 8; k++) begin
      got = -1;
      for (int unsigned i = 0; i < 6 && got < 0; i++) begin
        @(posedge clk); #1;
        if (gnt0) got = 0;
        else if (gnt1) got = 1;
      end
      check("rr_order", got, int'(k % 2));
      if (got >= 0) begin
        push_exp(got);
        r_op[got] = 1'($urandom);
        r_a[got]  = 8'($urandom);
        r_b[got]  = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    if (gnt0) push_exp(0);
    if (gnt1) push_exp(1);
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;

    // Random requesters obeying the drop-on-grant rule.
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (r_req[p] && gnt_of(p)) begin
          push_exp(p);
          r_req[p]    = 1'b0;
          r_a[p]      = 8'($urandom);
          r_b[p]      = 8'($urandom);
          wait_cnt[p] = 0;
        end else if (r_req[p]) begin
          wait_cnt[p]++;
          if (wait_cnt[p] > 6) begin
            tests++;
            fails++;
            $display("FAIL starvation: port %0d waited %0d cycles, expected at most 6", p, wait_cnt[p]);
            r_req[p]    = 1'b0;
            wait_cnt[p] = 0;
          end
        end else if ($urandom_range(1, 0) == 1) begin
          r_req[p] = 1'b1;
          r_op[p]  = 1'($urandom);
          if ($urandom_range(7, 0) == 0) begin
            r_a[p] = 8'($urandom);
            r_b[p] = r_a[p];
          end else begin
            r_a[p] = 8'($urandom);
            r_b[p] = 8'($urandom);
          end
        end
      end
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
